// File: rtl/rp_harness_pkg.sv
// Shared command codes, error code and FSM state encoding for the
// byte-stream harness engine.
package rp_harness_pkg;

  localparam logic [7:0] CMD_READ    = 8'h68;  // 'h'
  localparam logic [7:0] CMD_HALT    = 8'h69;  // 'i'
  localparam logic [7:0] CMD_RST_ON  = 8'h6A;  // 'j'
  localparam logic [7:0] CMD_RST_OFF = 8'h6B;  // 'k'
  localparam logic [7:0] CMD_STEP1   = 8'h6C;  // 'l'
  localparam logic [7:0] CMD_LOAD    = 8'h6D;  // 'm'
  localparam logic [7:0] CMD_STEPN   = 8'h70;  // 'p'
  localparam logic [7:0] ERR_CODE    = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_STEP,
    ST_SEND,
    ST_HALT
  } state_t;

  function automatic int byte_count(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/rp_byte_serializer.sv
// Emits a loaded parallel word as an LSB-first byte stream over valid/ready;
// LEN bytes are sent and the byte on tx_data is held until it is taken.
module rp_byte_serializer #(
  parameter int NBYTES = 4,
  parameter int LW     = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [NBYTES*8-1:0]   load_data,
  input  logic [LW-1:0]         load_len,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  done
);

  logic [NBYTES*8-1:0] shreg;
  logic [NBYTES*8-1:0] shreg_nxt;
  logic [LW-1:0]       remaining;

  assign shreg_nxt = shreg >> 8;
  assign done      = tx_valid && tx_ready && (remaining == LW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      remaining <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
    end else if (load) begin
      shreg     <= load_data;
      remaining <= load_len;
      tx_valid  <= 1'b1;
      tx_data   <= load_data[7:0];
    end else if (tx_valid && tx_ready) begin
      if (remaining == LW'(1)) begin
        tx_valid <= 1'b0;
      end else begin
        shreg     <= shreg_nxt;
        tx_data   <= shreg_nxt[7:0];
        remaining <= remaining - LW'(1);
      end
    end
  end

endmodule

// File: rtl/rp_stream_harness.sv
// Byte-stream command engine: decodes host commands, loads the target input
// vector, steps the target through dut_ce and streams output snapshots back.
module rp_stream_harness
  import rp_harness_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int STEP_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [IN_WIDTH-1:0]  dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 dut_rst,
  output logic                 dut_ce,
  output logic                 halted
);

  localparam int IN_BYTES  = byte_count(IN_WIDTH);
  localparam int OUT_BYTES = byte_count(OUT_WIDTH);
  localparam int BCW       = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam int LW        = $clog2(OUT_BYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(IN_BYTES - 1);
  localparam logic [LW-1:0]  SNAP_LEN  = LW'(OUT_BYTES);
  localparam logic [LW-1:0]  ERR_LEN   = LW'(1);

  state_t                state;
  state_t                state_nxt;
  logic [IN_BYTES*8-1:0] shadow;
  logic [IN_BYTES*8-1:0] shadow_nxt;
  logic [BCW-1:0]        byte_cnt;
  logic [7:0]            cnt_lo;
  logic [STEP_W-1:0]     step_cnt;
  logic [STEP_W-1:0]     cnt_n;
  logic                  err_q;
  logic                  rx_fire;
  logic                  ser_load;
  logic                  ser_err;
  logic                  ser_done;
  logic [OUT_BYTES*8-1:0] ser_data;
  logic [LW-1:0]         ser_len;

  assign rx_fire  = rx_valid && rx_ready;
  assign rx_ready = !rst && (state inside {ST_IDLE, ST_LOAD, ST_CNT_LO, ST_CNT_HI, ST_HALT});
  assign dut_ce   = (state == ST_STEP);
  assign halted   = (state == ST_HALT);

  // Step count is the little-endian pair truncated to STEP_W bits.
  generate
    if (STEP_W > 8) begin : g_cnt_wide
      assign cnt_n = {rx_data[STEP_W-9:0], cnt_lo};
    end else begin : g_cnt_narrow
      assign cnt_n = cnt_lo[STEP_W-1:0];
    end
  endgenerate

  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[{byte_cnt, 3'b000} +: 8] = rx_data;
  end

  // Snapshot is zero-padded; an error reply reuses the same path with one byte.
  always_comb begin
    ser_data = '0;
    if (ser_err) begin
      ser_data[7:0] = ERR_CODE;
    end else begin
      ser_data[OUT_WIDTH-1:0] = dut_out;
    end
    ser_len = ser_err ? ERR_LEN : SNAP_LEN;
  end

  always_comb begin
    state_nxt = state;
    ser_load  = 1'b0;
    ser_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            CMD_READ: begin
              ser_load  = 1'b1;
              state_nxt = ST_SEND;
            end
            CMD_HALT:    state_nxt = ST_HALT;
            CMD_RST_ON:  state_nxt = ST_IDLE;
            CMD_RST_OFF: state_nxt = ST_IDLE;
            CMD_STEP1:   state_nxt = ST_STEP;
            CMD_LOAD:    state_nxt = ST_LOAD;
            CMD_STEPN:   state_nxt = ST_CNT_LO;
            default: begin
              ser_load  = 1'b1;
              ser_err   = 1'b1;
              state_nxt = ST_SEND;
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (rx_fire && (byte_cnt == LAST_BYTE)) state_nxt = ST_IDLE;
      end
      ST_CNT_LO: begin
        if (rx_fire) state_nxt = ST_CNT_HI;
      end
      ST_CNT_HI: begin
        if (rx_fire) state_nxt = (cnt_n == '0) ? ST_IDLE : ST_STEP;
      end
      ST_STEP: begin
        if (step_cnt == STEP_W'(1)) state_nxt = ST_IDLE;
      end
      ST_SEND: begin
        if (ser_done) state_nxt = err_q ? ST_HALT : ST_IDLE;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shadow   <= '0;
      byte_cnt <= '0;
      cnt_lo   <= 8'h00;
      step_cnt <= '0;
      err_q    <= 1'b0;
      dut_in   <= '0;
      dut_rst  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (ser_load) err_q <= ser_err;
      case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            if (rx_data == CMD_RST_ON)  dut_rst  <= 1'b1;
            if (rx_data == CMD_RST_OFF) dut_rst  <= 1'b0;
            if (rx_data == CMD_STEP1)   step_cnt <= STEP_W'(1);
            if (rx_data == CMD_LOAD)    byte_cnt <= '0;
          end
        end
        // dut_in only ever takes a complete shadow word, never a partial one.
        ST_LOAD: begin
          if (rx_fire) begin
            shadow <= shadow_nxt;
            if (byte_cnt == LAST_BYTE) begin
              dut_in   <= shadow_nxt[IN_WIDTH-1:0];
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        ST_CNT_LO: begin
          if (rx_fire) cnt_lo <= rx_data;
        end
        ST_CNT_HI: begin
          if (rx_fire) step_cnt <= cnt_n;
        end
        ST_STEP: step_cnt <= step_cnt - STEP_W'(1);
        default: ;
      endcase
    end
  end

  rp_byte_serializer #(
    .NBYTES (OUT_BYTES),
    .LW     (LW)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (ser_data),
    .load_len  (ser_len),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_rp_stream_harness.sv
// Scenario bench for rp_stream_harness; tx bytes are checked against a queue
// of expected bytes filled when each read or error is provoked.
module tb_rp_stream_harness;

  localparam int IN_WIDTH  = 20;
  localparam int OUT_WIDTH = 32;
  localparam int STEP_W    = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [7:0]           rx_data = 8'h00;
  logic                 rx_valid = 1'b0;
  logic                 rx_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [IN_WIDTH-1:0]  dut_in;
  logic [OUT_WIDTH-1:0] dut_out = '0;
  logic                 dut_rst;
  logic                 dut_ce;
  logic                 halted;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         rdy_mode = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  rp_stream_harness #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .STEP_W    (STEP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .dut_rst  (dut_rst),
    .dut_ce   (dut_ce),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = (rdy_mode == 1) ? ~tx_ready : 1'b1;
    end
  end

  // tx monitor: byte order/value against the queue, plus hold-while-stalled
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          total++;
          if (!(tx_valid === 1'b1 && tx_data === stall_data)) begin
            bad++;
            $display("FAIL tx_hold: valid=%b data=%02h required valid=1 data=%02h", tx_valid, tx_data, stall_data);
          end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL tx_unexpected: got %02h required no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
              bad++;
              $display("FAIL tx_byte: got %02h required %02h", tx_data, e);
            end
          end
        end
        stall_prev = (tx_valid === 1'b1 && tx_ready === 1'b0);
        stall_data = tx_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL rx_accept: byte %02h not accepted, rx_ready=%b required 1", b, rx_ready);
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d bytes left required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rx_valid = 1'b0;
    rdy_mode = 0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready_in_rst: got %b required 0", rx_ready); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %b required 1", rx_ready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %02h required 00", tx_data); end
    total++; if (dut_in !== '0) begin bad++; $display("FAIL reset_dut_in: got %05h required 00000", dut_in); end
    total++; if (dut_rst !== 1'b1) begin bad++; $display("FAIL reset_dut_rst: got %b required 1", dut_rst); end
    total++; if (dut_ce !== 1'b0) begin bad++; $display("FAIL reset_dut_ce: got %b required 0", dut_ce); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b required 0", halted); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_dut_rst();
    send_byte(8'h6B);
    total++; if (dut_rst !== 1'b0) begin bad++; $display("FAIL rst_off: got %b required 0", dut_rst); end
    send_byte(8'h6A);
    total++; if (dut_rst !== 1'b1) begin bad++; $display("FAIL rst_on: got %b required 1", dut_rst); end
    send_byte(8'h6B);
    total++; if (dut_rst !== 1'b0) begin bad++; $display("FAIL rst_off2: got %b required 0", dut_rst); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_tx: tx_valid=%b required 0", tx_valid); end
  endtask

  task automatic test_load();
    send_byte(8'h6D);
    send_byte(8'h34);
    send_byte(8'h12);
    total++; if (dut_in !== 20'h00000) begin bad++; $display("FAIL load_partial: got %05h required 00000", dut_in); end
    send_byte(8'hFF);
    total++; if (dut_in !== 20'hF1234) begin bad++; $display("FAIL load_full: got %05h required F1234", dut_in); end
  endtask

  task automatic test_step();
    int ones;
    int ce_bad;
    logic rdy4, rdy5;
    send_byte(8'h6C);
    total++; if (dut_ce !== 1'b1) begin bad++; $display("FAIL step1_ce: got %b required 1", dut_ce); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL step1_busy: rx_ready=%b required 0", rx_ready); end
    @(posedge clk);
    #1;
    total++; if (dut_ce !== 1'b0) begin bad++; $display("FAIL step1_ce_off: got %b required 0", dut_ce); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL step1_ready: got %b required 1", rx_ready); end

    send_byte(8'h70);
    send_byte(8'h05);
    send_byte(8'h00);
    ones = 0;
    ce_bad = 0;
    rdy4 = 1'b0;
    rdy5 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dut_ce === 1'b1) ones++;
      if (dut_ce !== (i < 5)) ce_bad++;
      if (i == 4) rdy4 = rx_ready;
      if (i == 5) rdy5 = rx_ready;
    end
    total++; if (ones != 5) begin bad++; $display("FAIL stepn_count: got %0d cycles required 5", ones); end
    total++; if (ce_bad != 0) begin bad++; $display("FAIL stepn_shape: %0d misplaced cycles required 0", ce_bad); end
    total++; if (rdy4 !== 1'b0 || rdy5 !== 1'b1) begin bad++; $display("FAIL stepn_ready: got %b%b required 01", rdy4, rdy5); end
    @(posedge clk);
    #1;

    send_byte(8'h70);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    total++; if (dut_ce !== 1'b0) begin bad++; $display("FAIL step0_ce: got %b required 0", dut_ce); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL step0_ready: got %b required 1", rx_ready); end
    @(posedge clk);
    #1;

    send_byte(8'h6A);
    send_byte(8'h6C);
    total++; if (dut_ce !== 1'b1 || dut_rst !== 1'b1) begin bad++; $display("FAIL step_in_rst: ce=%b rst=%b required 1 1", dut_ce, dut_rst); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_read();
    dut_out = 32'hDEADBEEF;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'hDE);
    rdy_mode = 1;
    send_byte(8'h68);
    dut_out = 32'h12345678;
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'hEF) begin bad++; $display("FAIL read_first: valid=%b data=%02h required 1 EF", tx_valid, tx_data); end
    wait_drain("read");
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL read_end: tx_valid=%b required 0", tx_valid); end
  endtask

  task automatic test_back_to_back();
    dut_out = 32'h000000A5;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    send_byte(8'h68);
    dut_out = 32'h11223344;
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    send_byte(8'h68);
    wait_drain("b2b");
  endtask

  task automatic test_error();
    int ce_seen;
    exp_q.push_back(8'hEE);
    send_byte(8'h41);
    wait_drain("err");
    repeat (2) @(posedge clk);
    #1;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL err_halted: got %b required 1", halted); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL err_drain_ready: got %b required 1", rx_ready); end
    send_byte(8'h6C);
    send_byte(8'h68);
    ce_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dut_ce !== 1'b0) ce_seen++;
    end
    total++; if (ce_seen != 0) begin bad++; $display("FAIL halt_step: got %0d ce cycles required 0", ce_seen); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_clear: got %b required 0", halted); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_load();
    send_byte(8'h6D);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(negedge clk);
    total++; if (dut_in !== '0) begin bad++; $display("FAIL midrst_dut_in: got %05h required 00000", dut_in); end
    total++; if (dut_rst !== 1'b1) begin bad++; $display("FAIL midrst_dut_rst: got %b required 1", dut_rst); end
    @(posedge clk);
    #1 rst = 1'b0;
    send_byte(8'h6D);
    send_byte(8'hAA);
    send_byte(8'hBB);
    total++; if (dut_in !== '0) begin bad++; $display("FAIL midrst_partial: got %05h required 00000", dut_in); end
    send_byte(8'hCC);
    total++; if (dut_in !== 20'hCBBAA) begin bad++; $display("FAIL midrst_reload: got %05h required CBBAA", dut_in); end
  endtask

  initial begin
    test_reset();
    test_dut_rst();
    test_load();
    test_step();
    test_read();
    test_back_to_back();
    test_error();
    test_reset_mid_load();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
